// File: rtl/sample_frame_tx_if.sv
// Sample stream handshake: valid/ready beat carrying one sample and an end-of-frame flag.
interface sample_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/sample_frame_tx.sv
// Frame-buffered sample transmitter: loads a frame and tracks its largest/second-largest, then streams it.
// Optional macro LOOP_EN adds a loop input that replays the buffered frame until loop is dropped.
module sample_frame_tx #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_full,
  output logic             wr_drop,
  input  logic             start,
  output logic             busy,
  output logic [CW-1:0]    frame_len,
  sample_frame_tx_if.master tx,
  output logic [WIDTH-1:0] exp_lar,
  output logic [WIDTH-1:0] exp_sec,
  output logic             done
`ifdef LOOP_EN
  , input  logic           loop
`endif
);

  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_fresh, r_tx_valid, r_tx_last, r_wr_drop, r_done;
  logic [WIDTH-1:0] r_tx_data, r_exp_lar, r_exp_sec;

  logic             w_full, w_wr_ok, w_start_ok, w_accept, w_last_acc, w_loop;
  logic [AW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_base_lar, w_base_sec;

`ifdef LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_full     = (r_count == C_FULL);
  assign w_wr_ok    = wr_en & (r_state == S_IDLE) & ~w_full;
  assign w_start_ok = start & (r_state == S_IDLE) & (r_count != '0);
  assign w_accept   = r_tx_valid & tx.tx_ready;
  assign w_last_acc = w_accept & r_tx_last;
  assign w_rd_nxt   = r_rd_ptr + A_ONE;
  // The first write of a new frame ranks against zero, not the previous frame's result.
  assign w_base_lar = r_fresh ? '0 : r_exp_lar;
  assign w_base_sec = r_fresh ? '0 : r_exp_sec;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_nstate = S_SEND;
      S_SEND:  if (w_last_acc && !w_loop) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fresh    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_data  <= '0;
      r_exp_lar  <= '0;
      r_exp_sec  <= '0;
      r_wr_drop  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_drop <= wr_en & ((r_state == S_SEND) | w_full);
      r_done    <= w_last_acc;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + A_ONE;
        r_count  <= r_count + C_ONE;
        r_fresh  <= 1'b0;
        if (wr_data >= w_base_lar) begin
          r_exp_sec <= w_base_lar;
          r_exp_lar <= wr_data;
        end else begin
          r_exp_lar <= w_base_lar;
          r_exp_sec <= (wr_data > w_base_sec) ? wr_data : w_base_sec;
        end
      end
      if (w_start_ok) begin
        r_tx_valid <= 1'b1;
        r_rd_ptr   <= '0;
        r_tx_data  <= r_mem[0];
        r_tx_last  <= (r_count == C_ONE);
      end else if (w_accept) begin
        if (!r_tx_last) begin
          r_rd_ptr  <= w_rd_nxt;
          r_tx_data <= r_mem[w_rd_nxt];
          r_tx_last <= (CW'(w_rd_nxt) == r_count - C_ONE);
        end else if (w_loop) begin
          r_rd_ptr  <= '0;
          r_tx_data <= r_mem[0];
          r_tx_last <= (r_count == C_ONE);
        end else begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_rd_ptr   <= '0;
          r_wr_ptr   <= '0;
          r_count    <= '0;
          r_fresh    <= 1'b1;
        end
      end
    end
  end

  assign tx.tx_valid = r_tx_valid;
  assign tx.tx_data  = r_tx_data;
  assign tx.tx_last  = r_tx_last;
  assign wr_full     = w_full;
  assign wr_drop     = r_wr_drop;
  assign busy        = (r_state == S_SEND);
  assign frame_len   = r_count;
  assign exp_lar     = r_exp_lar;
  assign exp_sec     = r_exp_sec;
  assign done        = r_done;

endmodule
